serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, clocked successor to the team's gate-level 1-bit full adder.
- A single full-adder cell is reused once per clock to add two WIDTH-bit operands LSB-first.
- Start/busy/done handshake, registered carry and signed overflow flag.
- Arithmetic datapath building block for the lab CPU, where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in to bit 0; captured on the accepting edge
- sub  input  1  subtract mode; captured on the accepting edge; ignored unless SERIAL_ADDER_SUB_EN
- sum  output  WIDTH  result; holds the last completed value until the next accept
- cout  output  1  carry out of the MSB
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum, cout and ovf become valid

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; shift registers, carry flop and bit counter cleared.
- Reset mid-operation aborts immediately; outputs take their reset values; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0:
  - capture a, b and sub into shift registers;
  - load the carry flop with cin;
  - counter=0; go to RUN; busy=1 from E0.
- RUN: on each edge, one bit is produced.
  - s = a_sh[0] ^ b_sh[0] ^ c
  - c' = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]))
  - s shifts into the MSB end of the result register; a_sh and b_sh shift right; counter increments.
  - Bit k is produced on edge E(k+1).
  - On edge E(WIDTH): last bit done; capture the carry into the MSB as well as the carry out; go to DONE.
- DONE (exactly one cycle): done=1, busy=0.
  - sum, cout and ovf update on edge E(WIDTH) and are stable from then on.
  - Latency: done is high in the cycle following edge E(WIDTH).
- DONE exit:
  - start=1 goes straight to RUN (back-to-back accept with new operands; sum/cout/ovf hold old values until the new E(WIDTH));
  - start=0 goes to IDLE.
- start in RUN is ignored; no queueing; a and b may change freely while busy.
- Widths:
  - sum wraps modulo 2^WIDTH;
  - cout is the unsigned carry;
  - ovf uses the two's-complement interpretation.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: when captured sub=1, b is inverted bitwise at capture and the initial carry is forced to 1, ignoring cin, giving a-b.
  - cout=1 means no borrow.
  - ovf is signed subtraction overflow.
- Undefined: the sub port exists but is unused; the block always adds with cin.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the counter width function clog2(WIDTH+1).
- Sub-module fa_cell: gate-level full adder built from xor, and and or primitives, mirroring the team's existing 1-bit adder.
  - Ports a, b, cin, z, cout.
  - Instantiated once in the datapath.

Test Plan:
- WIDTH=8: a=8'h3C, b=8'h05, cin=0, pulse start -> busy for 8 cycles, done pulse in cycle 9, sum=8'h41, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Exhaustive WIDTH=4 sweep (a, b, cin over all values, as in the 1-bit bench loops) -> {cout,sum}==a+b+cin every run; print PASS or FAIL per vector.
- Assert start again during RUN with different operands -> ignored; result reflects the first operands; exactly one done pulse.
- start held high through DONE -> back-to-back accept; second result done pulse appears 9 cycles after the first.
- Drop rst_n at cycle 4 of RUN -> all outputs 0 immediately, state IDLE, no done pulse.
- With SERIAL_ADDER_SUB_EN: a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter sizing shared by the serial adder slice
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output sum, cout, ovf, busy, done
    );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: gate-level 1-bit full adder, the single cell reused every cycle by serial_adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic z,
    output logic cout
);

    logic p, g, t;

    xor x_p (p, a, b);
    xor x_z (z, p, cin);
    and a_g (g, a, b);
    and a_t (t, p, cin);
    or  o_c (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add of two WIDTH-bit operands; SERIAL_ADDER_SUB_EN enables a-b via sub
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s;
    logic             co;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so inversion and forced carry happen at capture.
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub | bus.cin;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign b_in       = bus.b;
    assign c_in       = bus.cin;
`endif

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .z    (s),
        .cout (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= b_in;
                        c        <= c_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= co;
                    res  <= {s, res[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    // Carry into the MSB is c on this last step, so ovf is c ^ co.
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.sum  <= {s, res[WIDTH-1:1]};
                        bus.cout <= co;
                        bus.ovf  <= c ^ co;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and an exhaustive WIDTH=4 sweep
module tb_serial_adder;
    import serial_adder_pkg::*;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done8 = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(4)) if4 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        logic [63:0] m, bb, full;
        logic        cc;
        exp_t        e;
        m  = (64'd1 << w) - 64'd1;
        bb = {32'd0, b};
        cc = ci;
        if (SUB_EN && sb) begin
            bb = ~bb & m;
            cc = 1'b1;
        end
        full   = {32'd0, a} + bb + {63'd0, cc};
        e.sum  = full[31:0] & m[31:0];
        e.cout = full[w];
        e.ovf  = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (if8.done) begin
            exp_t e;
            n_done8++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 64'(if8.done), 64'd0);
            end else begin
                e = q8.pop_front();
                check("sum8", 64'(if8.sum), 64'(e.sum));
                check("cout8", 64'(if8.cout), 64'(e.cout));
                check("ovf8", 64'(if8.ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (if4.done) begin
            exp_t e;
            if (q4.size() == 0) begin
                check("done4_unexpected", 64'(if4.done), 64'd0);
            end else begin
                e = q4.pop_front();
                check("sum_cout4", {59'd0, if4.cout, if4.sum}, {59'd0, e.cout, e.sum[3:0]});
                check("ovf4", 64'(if4.ovf), 64'(e.ovf));
            end
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                       output int lat, output int nb);
        @(negedge clk);
        if8.a     = a;
        if8.b     = b;
        if8.cin   = ci;
        if8.sub   = sb;
        if8.start = 1'b1;
        q8.push_back(model(8, {24'd0, a}, {24'd0, b}, ci, sb));
        lat = 0;
        nb  = 0;
        do begin
            @(negedge clk);
            if8.start = 1'b0;
            lat++;
            nb += int'(if8.busy);
        end while (!if8.done && lat < 40);
        if (!if8.done) check("timeout8", 64'(if8.done), 64'd1);
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int lat;
        @(negedge clk);
        if4.a     = a;
        if4.b     = b;
        if4.cin   = ci;
        if4.sub   = 1'b0;
        if4.start = 1'b1;
        q4.push_back(model(4, {28'd0, a}, {28'd0, b}, ci, 1'b0));
        lat = 0;
        do begin
            @(negedge clk);
            if4.start = 1'b0;
            lat++;
        end while (!if4.done && lat < 40);
        if (!if4.done) check("timeout4", 64'(if4.done), 64'd1);
    endtask

    initial begin
        int lat, nb, d0, t1, t2, g;
        {if8.start, if8.a, if8.b, if8.cin, if8.sub} = '0;
        {if4.start, if4.a, if4.b, if4.cin, if4.sub} = '0;
        repeat (2) @(negedge clk);
        check("rst_sum", 64'(if8.sum), 64'd0);
        check("rst_flags", {60'd0, if8.cout, if8.ovf, if8.busy, if8.done}, 64'd0);
        check("rst_state", 64'(dut8.state), 64'(IDLE));
        rst_n = 1'b1;

        go8(8'h3C, 8'h05, 1'b0, 1'b0, lat, nb);
        check("t1_latency", 64'(lat), 64'd9);
        check("t1_busy_cycles", 64'(nb), 64'd8);
        check("t1_sum", 64'(if8.sum), 64'h41);
        check("t1_cout_ovf", {62'd0, if8.cout, if8.ovf}, 64'd0);

        go8(8'hFF, 8'h01, 1'b0, 1'b0, lat, nb);
        check("t2_sum", 64'(if8.sum), 64'h00);
        check("t2_cout_ovf", {62'd0, if8.cout, if8.ovf}, 64'b10);

        go8(8'h7F, 8'h01, 1'b0, 1'b0, lat, nb);
        check("t3_sum", 64'(if8.sum), 64'h80);
        check("t3_cout_ovf", {62'd0, if8.cout, if8.ovf}, 64'b01);

        go8(8'h10, 8'h20, 1'b0, 1'b1, lat, nb);
        check("sub_sum", 64'(if8.sum), SUB_EN ? 64'hF0 : 64'h30);
        check("sub_cout", 64'(if8.cout), 64'd0);

        // start re-asserted mid-RUN with other operands must be ignored
        @(negedge clk);
        d0 = n_done8;
        {if8.a, if8.b, if8.cin, if8.sub} = {8'h12, 8'h34, 1'b1, 1'b0};
        if8.start = 1'b1;
        q8.push_back(model(8, 32'h12, 32'h34, 1'b1, 1'b0));
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        {if8.a, if8.b, if8.start} = {8'hAA, 8'h55, 1'b1};
        repeat (2) @(negedge clk);
        if8.start = 1'b0;
        g = 0;
        while (n_done8 == d0 && g < 40) begin @(negedge clk); g++; end
        repeat (12) @(negedge clk);
        check("run_start_one_done", 64'(n_done8 - d0), 64'd1);
        check("run_start_sum", 64'(if8.sum), 64'h47);

        // start held through DONE: back-to-back accept
        @(negedge clk);
        {if8.a, if8.b, if8.cin, if8.start} = {8'h01, 8'h02, 1'b0, 1'b1};
        q8.push_back(model(8, 32'h01, 32'h02, 1'b0, 1'b0));
        g = 0;
        do begin @(negedge clk); g++; end while (!if8.done && g < 40);
        t1 = cyc;
        {if8.a, if8.b} = {8'h10, 8'h20};
        q8.push_back(model(8, 32'h10, 32'h20, 1'b0, 1'b0));
        @(negedge clk);
        if8.start = 1'b0;
        check("b2b_hold_sum", 64'(if8.sum), 64'h03);
        check("b2b_busy", 64'(if8.busy), 64'd1);
        g = 0;
        while (!if8.done && g < 40) begin @(negedge clk); g++; end
        t2 = cyc;
        check("b2b_gap", 64'(t2 - t1), 64'd9);

        // asynchronous reset four cycles into RUN
        @(negedge clk);
        d0 = n_done8;
        {if8.a, if8.b, if8.start} = {8'hFF, 8'hFF, 1'b1};
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", 64'(if8.sum), 64'd0);
        check("abort_flags", {60'd0, if8.cout, if8.ovf, if8.busy, if8.done}, 64'd0);
        check("abort_state", 64'(dut8.state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(n_done8 - d0), 64'd0);

        for (int i = 0; i < 20; i++)
            go8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat, nb);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    go4(4'(i), 4'(j), 1'(k));

        repeat (3) @(negedge clk);
        check("sb8_drained", 64'(q8.size()), 64'd0);
        check("sb4_drained", 64'(q4.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
